// File: rtl/inst_buf_arb_if.sv
// Handshake/bus bundle for the shared instruction buffer.
// Signal names keep the buffer's point of view: i_* flow into the buffer,
// o_* flow out of it. "master" is the requester side, "slave" the buffer.
interface inst_buf_arb_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12
);
  logic                  i_core_req;
  logic [ADDR_W-1:0]     i_core_addr;
  logic                  o_core_gnt;
  logic [DATA_W-1:0]     o_core_rdata;
  logic                  o_core_rvld;

  logic                  i_host_req;
  logic                  i_host_we;
  logic [DATA_W/8-1:0]   i_host_be;
  logic [ADDR_W-1:0]     i_host_addr;
  logic [DATA_W-1:0]     i_host_wdata;
  logic                  o_host_gnt;
  logic [DATA_W-1:0]     o_host_rdata;
  logic                  o_host_rvld;

  logic                  o_par_err;

  modport master (
    output i_core_req, i_core_addr,
    input  o_core_gnt, o_core_rdata, o_core_rvld,
    output i_host_req, i_host_we, i_host_be, i_host_addr, i_host_wdata,
    input  o_host_gnt, o_host_rdata, o_host_rvld,
    input  o_par_err
  );

  modport slave (
    input  i_core_req, i_core_addr,
    output o_core_gnt, o_core_rdata, o_core_rvld,
    input  i_host_req, i_host_we, i_host_be, i_host_addr, i_host_wdata,
    output o_host_gnt, o_host_rdata, o_host_rvld,
    output o_par_err
  );
endinterface

// File: rtl/inst_buf_arb.sv
// Instruction buffer: one single-port SRAM shared by the NPU core fetch port
// (read only) and the host port (read/write with byte enables).
// Core has priority; the host is forced a grant after STARVE_MAX lost
// contended cycles. A 1-bit owner tag travels with each read so the data
// return is steered to the right rvld.
// Optional byte parity: define INST_BUF_PARITY_EN to store one even-parity
// bit per byte above the data and flag mismatches on read (o_par_err).
// Also holds sramsp_wrapper, a behavioural model of the SRAM macro wrapper.
module inst_buf_arb #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 12,
  parameter int REG_OUT    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  inst_buf_arb_if.slave    bus
);
  localparam int NB = DATA_W / 8;
`ifdef INST_BUF_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     starve_q, starve_d;
  logic              starved;
  logic              core_gnt, host_gnt, host_wr, rd_issue;
  logic              rd_vld_q, rd_vld_d, rd_own_q, rd_own_d;
  logic              core_ret, host_ret, par_err_ret;

  logic              sram_cen, sram_gwen;
  logic [ADDR_W-1:0] sram_a;
  logic [MEM_W-1:0]  sram_wen, sram_d, sram_q;

  // Arbitration: core wins contention until the host has lost STARVE_MAX times
  assign starved  = (starve_q == STARVE_LIM);
  assign core_gnt = bus.i_core_req & ~(bus.i_host_req & starved);
  assign host_gnt = bus.i_host_req & (~bus.i_core_req | starved);
  assign bus.o_core_gnt = core_gnt;
  assign bus.o_host_gnt = host_gnt;

  assign host_wr  = host_gnt & bus.i_host_we;
  assign rd_issue = core_gnt | (host_gnt & ~bus.i_host_we);
  assign rd_vld_d = rd_issue;
  assign rd_own_d = host_gnt;

  // Starvation counter: counts host losses, clears on host grant or host idle
  always_comb begin
    starve_d = starve_q;
    if (!bus.i_host_req || host_gnt) begin
      starve_d = '0;
    end else if (core_gnt) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Arbiter state and read owner tag pipeline
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign sram_cen  = ~(core_gnt | host_gnt);
  assign sram_gwen = ~host_wr;
  assign sram_a    = host_gnt ? bus.i_host_addr : bus.i_core_addr;

  // Byte enables to active-low bit write enables; parity bits follow their byte
  always_comb begin
    sram_wen = '1;
    sram_d   = '0;
    sram_d[DATA_W-1:0] = bus.i_host_wdata;
    for (int b = 0; b < NB; b++) begin
      if (host_wr && bus.i_host_be[b]) begin
        sram_wen[b*8 +: 8] = 8'h00;
      end
`ifdef INST_BUF_PARITY_EN
      sram_d[DATA_W+b] = ^bus.i_host_wdata[b*8 +: 8];
      if (host_wr && bus.i_host_be[b]) begin
        sram_wen[DATA_W+b] = 1'b0;
      end
`endif
    end
  end

  sramsp_wrapper #(
    .ADDR_W (ADDR_W),
    .MEM_W  (MEM_W)
  ) u_sram (
    .CLK   (i_clk),
    .CEN   (sram_cen),
    .GWEN  (sram_gwen),
    .WEN   (sram_wen),
    .A     (sram_a),
    .D     (sram_d),
    .Q     (sram_q),
    .EMA   (3'b010),
    .EMAW  (2'b00),
    .RET1N (1'b1),
    .TEN   (1'b1)
  );

  assign core_ret = rd_vld_q & ~rd_own_q;
  assign host_ret = rd_vld_q &  rd_own_q;

`ifdef INST_BUF_PARITY_EN
  logic par_mis;

  // Recompute even parity over each returned byte against its stored bit
  always_comb begin
    par_mis = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (^{sram_q[DATA_W+b], sram_q[b*8 +: 8]}) begin
        par_mis = 1'b1;
      end
    end
  end

  assign par_err_ret = rd_vld_q & par_mis;
`else
  assign par_err_ret = 1'b0;
`endif

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_W-1:0] core_rdata_q, host_rdata_q;
    logic              core_rvld_q, host_rvld_q, par_err_q;

    // Per-port output registers, each loaded only on its own data return
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        core_rdata_q <= '0;
        host_rdata_q <= '0;
        core_rvld_q  <= 1'b0;
        host_rvld_q  <= 1'b0;
        par_err_q    <= 1'b0;
      end else begin
        core_rvld_q <= core_ret;
        host_rvld_q <= host_ret;
        par_err_q   <= par_err_ret;
        if (core_ret) begin
          core_rdata_q <= sram_q[DATA_W-1:0];
        end
        if (host_ret) begin
          host_rdata_q <= sram_q[DATA_W-1:0];
        end
      end
    end

    assign bus.o_core_rdata = core_rdata_q;
    assign bus.o_host_rdata = host_rdata_q;
    assign bus.o_core_rvld  = core_rvld_q;
    assign bus.o_host_rvld  = host_rvld_q;
    assign bus.o_par_err    = par_err_q;
  end else begin : g_comb_out
    assign bus.o_core_rdata = sram_q[DATA_W-1:0];
    assign bus.o_host_rdata = sram_q[DATA_W-1:0];
    assign bus.o_core_rvld  = core_ret;
    assign bus.o_host_rvld  = host_ret;
    assign bus.o_par_err    = par_err_ret;
  end
endmodule

// Behavioural single-port SRAM wrapper: active-low CEN/GWEN/WEN, bitwise
// write mask, 1-cycle registered read; Q holds on write and idle cycles.
module sramsp_wrapper #(
  parameter int ADDR_W = 12,
  parameter int MEM_W  = 128
) (
  input  logic              CLK,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [MEM_W-1:0]  WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [MEM_W-1:0]  D,
  output logic [MEM_W-1:0]  Q,
  input  logic [2:0]        EMA,
  input  logic [1:0]        EMAW,
  input  logic              RET1N,
  input  logic              TEN
);
  logic [MEM_W-1:0] mem_q [2**ADDR_W];
  logic [MEM_W-1:0] q_q;
  logic             unused_margin;

  // Margin settings only tune the hard macro timing
  assign unused_margin = ^{EMA, EMAW};

  // Array access: masked write or registered read
  always_ff @(posedge CLK) begin
    if (!CEN && RET1N && TEN) begin
      if (!GWEN) begin
        mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
      end else begin
        q_q <= mem_q[A];
      end
    end
  end

  assign Q = q_q;
endmodule

// File: tb/tb_inst_buf_arb.sv
// Bench for inst_buf_arb: per-cycle vector table on a REG_OUT=0 instance,
// hand sequences on a REG_OUT=1 instance, reset mid-read and (when
// INST_BUF_PARITY_EN is defined) a parity fault injection.
module tb_inst_buf_arb;
  localparam int DW = 128;
  localparam int AW = 12;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  inst_buf_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  inst_buf_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  inst_buf_arb #(.DATA_W(DW), .ADDR_W(AW), .REG_OUT(0), .STARVE_MAX(4)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  inst_buf_arb #(.DATA_W(DW), .ADDR_W(AW), .REG_OUT(1), .STARVE_MAX(4)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           creq;
    logic [AW-1:0]  caddr;
    logic           hreq;
    logic           hwe;
    logic [15:0]    hbe;
    logic [AW-1:0]  haddr;
    logic [DW-1:0]  hwd;
    logic           e_cgnt;
    logic           e_hgnt;
    logic           e_crv;
    logic           e_hrv;
    logic [DW-1:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [DW-1:0] W0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [DW-1:0] WP = 128'h5555555555555555_555555555555AAAA;
  localparam logic [DW-1:0] W1 = 128'h0123456789ABCDEF_FEDCBA987654AAAA;
  localparam logic [DW-1:0] W2 = 128'hDEADBEEF0BADF00D_CAFEBABE13579BDF;
  localparam logic [DW-1:0] W3 = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  localparam logic [DW-1:0] ZZ = '0;

  function automatic vec_t mk(logic creq, logic [AW-1:0] caddr, logic hreq, logic hwe,
                              logic [15:0] hbe, logic [AW-1:0] haddr, logic [DW-1:0] hwd,
                              logic ecg, logic ehg, logic ecr, logic ehr, logic [DW-1:0] ed);
    vec_t v;
    v.creq = creq; v.caddr = caddr; v.hreq = hreq; v.hwe = hwe; v.hbe = hbe;
    v.haddr = haddr; v.hwd = hwd;
    v.e_cgnt = ecg; v.e_hgnt = ehg; v.e_crv = ecr; v.e_hrv = ehr; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic idle_all();
    bus0.i_core_req = 0; bus0.i_core_addr = '0; bus0.i_host_req = 0; bus0.i_host_we = 0;
    bus0.i_host_be = '0; bus0.i_host_addr = '0; bus0.i_host_wdata = '0;
    bus1.i_core_req = 0; bus1.i_core_addr = '0; bus1.i_host_req = 0; bus1.i_host_we = 0;
    bus1.i_host_be = '0; bus1.i_host_addr = '0; bus1.i_host_wdata = '0;
  endtask

  task automatic host1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.i_host_req = 1; bus1.i_host_we = we; bus1.i_host_be = 16'hFFFF;
    bus1.i_host_addr = a; bus1.i_host_wdata = d;
  endtask

  initial begin
`ifdef INST_BUF_PARITY_EN
    logic [DW+15:0] tmp;
`endif
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    idle_all();

    // Reset state
    @(negedge clk); #1;
    chk("rst core_rvld0", bus0.o_core_rvld, 0);
    chk("rst host_rvld0", bus0.o_host_rvld, 0);
    chk("rst par_err0",   bus0.o_par_err, 0);
    chk("rst core_gnt0",  bus0.o_core_gnt, 0);
    chk("rst host_gnt0",  bus0.o_host_gnt, 0);
    chk("rst core_rvld1", bus1.o_core_rvld, 0);
    chk("rst host_rvld1", bus1.o_host_rvld, 0);
    chk("rst core_rdata1", bus1.o_core_rdata, ZZ);
    chk("rst host_rdata1", bus1.o_host_rdata, ZZ);
    @(negedge clk);
    rst_n = 1'b1;

    //               creq ca      hreq we be       ha      wd  | cg hg cr hr data
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 0, 0, ZZ));
    vecs.push_back(mk(0, 12'h000, 1, 1, 16'hFFFF, 12'h005, W0, 0, 1, 0, 0, ZZ));
    vecs.push_back(mk(1, 12'h005, 0, 0, 16'h0000, 12'h000, ZZ, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 1, 0, W0));
    vecs.push_back(mk(0, 12'h000, 1, 1, 16'h0003, 12'h005, WP, 0, 1, 0, 0, ZZ));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h005, ZZ, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(0, 12'h000, 1, 0, 16'h0000, 12'h005, ZZ, 0, 1, 1, 0, W1));
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 0, 1, W1));
    vecs.push_back(mk(1, 12'h005, 1, 1, 16'hFFFF, 12'h006, W2, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(1, 12'h005, 1, 1, 16'hFFFF, 12'h006, W2, 1, 0, 1, 0, W1));
    vecs.push_back(mk(0, 12'h000, 1, 1, 16'hFFFF, 12'h006, W2, 0, 1, 1, 0, W1));
    vecs.push_back(mk(1, 12'h006, 0, 0, 16'h0000, 12'h000, ZZ, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 1, 0, W2));
    // Continuous contention: 4 core grants then 1 host grant, repeating
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 0, 1, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 0, 1, W2));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 0, 1, 1, 0, W1));
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 0, 1, W2));
    // Host dropping its request clears the starvation count
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 0, 0, ZZ));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 0, 0, 16'h0000, 12'h000, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 1, 0, 1, 0, W1));
    vecs.push_back(mk(1, 12'h005, 1, 0, 16'h0000, 12'h006, ZZ, 0, 1, 1, 0, W1));
    vecs.push_back(mk(0, 12'h000, 0, 0, 16'h0000, 12'h000, ZZ, 0, 0, 0, 1, W2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus0.i_core_req   = vecs[i].creq;
      bus0.i_core_addr  = vecs[i].caddr;
      bus0.i_host_req   = vecs[i].hreq;
      bus0.i_host_we    = vecs[i].hwe;
      bus0.i_host_be    = vecs[i].hbe;
      bus0.i_host_addr  = vecs[i].haddr;
      bus0.i_host_wdata = vecs[i].hwd;
      #1;
      chk($sformatf("v%0d core_gnt", i),  bus0.o_core_gnt,  vecs[i].e_cgnt);
      chk($sformatf("v%0d host_gnt", i),  bus0.o_host_gnt,  vecs[i].e_hgnt);
      chk($sformatf("v%0d core_rvld", i), bus0.o_core_rvld, vecs[i].e_crv);
      chk($sformatf("v%0d host_rvld", i), bus0.o_host_rvld, vecs[i].e_hrv);
      chk($sformatf("v%0d par_err", i),   bus0.o_par_err,   0);
      if (vecs[i].e_crv) chk($sformatf("v%0d core_rdata", i), bus0.o_core_rdata, vecs[i].e_data);
      if (vecs[i].e_hrv) chk($sformatf("v%0d host_rdata", i), bus0.o_host_rdata, vecs[i].e_data);
    end
    idle_all();

    // REG_OUT=1: 2-cycle latency, per-port registers hold between returns
    @(negedge clk); host1(1, 12'hFFF, W3); #1;
    chk("r1 wr fff gnt", bus1.o_host_gnt, 1);
    @(negedge clk); host1(1, 12'h005, W0); #1;
    chk("r1 wr 005 gnt", bus1.o_host_gnt, 1);
    @(negedge clk); idle_all(); bus1.i_core_req = 1; bus1.i_core_addr = 12'h005; #1;
    chk("r1 core gnt", bus1.o_core_gnt, 1);
    @(negedge clk); idle_all(); #1;
    chk("r1 core rvld lat1", bus1.o_core_rvld, 0);
    @(negedge clk); #1;
    chk("r1 core rvld lat2", bus1.o_core_rvld, 1);
    chk("r1 core rdata", bus1.o_core_rdata, W0);
    @(negedge clk); host1(0, 12'hFFF, ZZ); #1;
    chk("r1 host rd gnt", bus1.o_host_gnt, 1);
    chk("r1 core rvld off", bus1.o_core_rvld, 0);
    @(negedge clk); idle_all(); #1;
    chk("r1 host rvld lat1", bus1.o_host_rvld, 0);
    @(negedge clk); #1;
    chk("r1 host rvld lat2", bus1.o_host_rvld, 1);
    chk("r1 host rdata fff", bus1.o_host_rdata, W3);
    chk("r1 core rdata held", bus1.o_core_rdata, W0);
    chk("r1 core rvld quiet", bus1.o_core_rvld, 0);
    @(negedge clk); #1;
    chk("r1 host rvld pulse", bus1.o_host_rvld, 0);
    chk("r1 host rdata held", bus1.o_host_rdata, W3);

`ifdef INST_BUF_PARITY_EN
    // Parity: corrupt one stored data bit behind the buffer's back
    @(negedge clk);
    bus0.i_host_req = 1; bus0.i_host_we = 1; bus0.i_host_be = 16'hFFFF;
    bus0.i_host_addr = 12'h010; bus0.i_host_wdata = W2;
    @(negedge clk); idle_all();
    tmp = dut0.u_sram.mem_q[12'h010];
    tmp[3] = ~tmp[3];
    dut0.u_sram.mem_q[12'h010] = tmp;
    @(negedge clk); bus0.i_core_req = 1; bus0.i_core_addr = 12'h010;
    @(negedge clk); bus0.i_core_addr = 12'h005; #1;
    chk("par bad rvld", bus0.o_core_rvld, 1);
    chk("par bad err", bus0.o_par_err, 1);
    @(negedge clk); idle_all(); #1;
    chk("par clean rvld", bus0.o_core_rvld, 1);
    chk("par clean err", bus0.o_par_err, 0);
`endif

    // Reset asserted mid-read: pending rvld is dropped
    @(negedge clk);
    bus0.i_core_req = 1; bus0.i_core_addr = 12'h005;
    bus1.i_core_req = 1; bus1.i_core_addr = 12'h005;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mrst core_rvld0", bus0.o_core_rvld, 0);
    chk("mrst par_err0", bus0.o_par_err, 0);
    chk("mrst core_rvld1", bus1.o_core_rvld, 0);
    chk("mrst core_rdata1", bus1.o_core_rdata, ZZ);
    chk("mrst host_rdata1", bus1.o_host_rdata, ZZ);
    @(negedge clk); idle_all();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post rst%0d core_rvld0", k), bus0.o_core_rvld, 0);
      chk($sformatf("post rst%0d core_rvld1", k), bus1.o_core_rvld, 0);
      chk($sformatf("post rst%0d host_rvld1", k), bus1.o_host_rvld, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
